// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM driving the shared datapath and ALU
module multicycle_ctrl #(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] Op,
    input  logic [FN_W-1:0] Funct,
    input  logic            Zero,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic [1:0]      NPCOp,
    output logic            IRWrite,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic            EXTOp,
    output logic [1:0]      GPRSel,
    output logic [1:0]      WDSel,
    output logic [4:0]      ALUOp,
    output logic [2:0]      state,
    output logic            illegal
);

    localparam logic [4:0] ALUOp_ADDU = 5'd0;
    localparam logic [4:0] ALUOp_SUBU = 5'd1;
    localparam logic [4:0] ALUOp_ADD  = 5'd2;
    localparam logic [4:0] ALUOp_SUB  = 5'd3;
    localparam logic [4:0] ALUOp_SLT  = 5'd4;
    localparam logic [4:0] ALUOp_AND  = 5'd5;
    localparam logic [4:0] ALUOp_OR   = 5'd6;
    localparam logic [4:0] ALUOp_SLL  = 5'd7;
    localparam logic [4:0] ALUOp_SRL  = 5'd8;
    localparam logic [4:0] ALUOp_SRA  = 5'd9;
    localparam logic [4:0] ALUOp_ADDI = 5'd10;
    localparam logic [4:0] ALUOp_SLTI = 5'd11;
    localparam logic [4:0] ALUOp_ORI  = 5'd12;
    localparam logic [4:0] ALUOp_LUI  = 5'd13;
    localparam logic [4:0] ALUOp_EQL  = 5'd14;
    localparam logic [4:0] ALUOp_BNE  = 5'd15;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

    localparam logic [FN_W-1:0] FN_SLL  = FN_W'(6'b000000);
    localparam logic [FN_W-1:0] FN_SRL  = FN_W'(6'b000010);
    localparam logic [FN_W-1:0] FN_SRA  = FN_W'(6'b000011);
    localparam logic [FN_W-1:0] FN_JR   = FN_W'(6'b001000);
    localparam logic [FN_W-1:0] FN_ADD  = FN_W'(6'b100000);
    localparam logic [FN_W-1:0] FN_ADDU = FN_W'(6'b100001);
    localparam logic [FN_W-1:0] FN_SUB  = FN_W'(6'b100010);
    localparam logic [FN_W-1:0] FN_SUBU = FN_W'(6'b100011);
    localparam logic [FN_W-1:0] FN_AND  = FN_W'(6'b100100);
    localparam logic [FN_W-1:0] FN_OR   = FN_W'(6'b100101);
    localparam logic [FN_W-1:0] FN_SLT  = FN_W'(6'b101010);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic       is_rtype, is_jr, is_j, is_jal, is_beq, is_bne;
    logic       is_ialu, is_lw, is_sw, legal;
    logic [4:0] r_aluop, i_aluop;
    logic       i_ext;

    // IR holds Op/Funct stable from ID on, so decode stays combinational
    always_comb begin
        is_rtype = 1'b0;
        is_jr    = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_ialu  = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        r_aluop  = ALUOp_ADDU;
        i_aluop  = ALUOp_ADDU;
        i_ext    = 1'b0;
        case (Op)
            OP_RTYPE: begin
                is_rtype = 1'b1;
                case (Funct)
                    FN_ADDU: r_aluop = ALUOp_ADDU;
                    FN_SUBU: r_aluop = ALUOp_SUBU;
                    FN_ADD:  r_aluop = ALUOp_ADD;
                    FN_SUB:  r_aluop = ALUOp_SUB;
                    FN_SLT:  r_aluop = ALUOp_SLT;
                    FN_AND:  r_aluop = ALUOp_AND;
                    FN_OR:   r_aluop = ALUOp_OR;
                    FN_SLL:  r_aluop = ALUOp_SLL;
                    FN_SRL:  r_aluop = ALUOp_SRL;
                    FN_SRA:  r_aluop = ALUOp_SRA;
                    FN_JR: begin
                        is_rtype = 1'b0;
                        is_jr    = 1'b1;
                    end
                    default: is_rtype = 1'b0;
                endcase
            end
            OP_J:    is_j   = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_ADDI: begin
                is_ialu = 1'b1;
                i_aluop = ALUOp_ADDI;
                i_ext   = 1'b1;
            end
            OP_SLTI: begin
                is_ialu = 1'b1;
                i_aluop = ALUOp_SLTI;
                i_ext   = 1'b1;
            end
            OP_ORI: begin
                is_ialu = 1'b1;
                i_aluop = ALUOp_ORI;
            end
            OP_LUI: begin
                is_ialu = 1'b1;
                i_aluop = ALUOp_LUI;
            end
            OP_LW:   is_lw = 1'b1;
            OP_SW:   is_sw = 1'b1;
            default: ;
        endcase
    end

    assign legal = is_rtype | is_jr | is_j | is_jal | is_beq | is_bne
                 | is_ialu | is_lw | is_sw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = S_ID;
            S_ID:  state_d = (!legal || is_j || is_jal || is_jr) ? S_IF : S_EXE;
            S_EXE: begin
                if (is_beq || is_bne)     state_d = S_IF;
                else if (is_lw || is_sw)  state_d = S_MEM;
                else                      state_d = S_WB;
            end
            S_MEM: state_d = is_lw ? S_WB : S_IF;
            S_WB:  state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    assign state = state_q;

    // rst gates outputs so no strobe can leak out while the FSM is being cleared
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        NPCOp       = 2'd0;
        IRWrite     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        EXTOp       = 1'b0;
        GPRSel      = 2'd0;
        WDSel       = 2'd0;
        ALUOp       = ALUOp_ADDU;
        illegal     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'd1;
                end
                S_ID: begin
                    ALUSrcB = 2'd2;
                    EXTOp   = 1'b1;
                    if (!legal) begin
                        illegal = 1'b1;
                    end else if (is_j || is_jal) begin
                        PCWrite = 1'b1;
                        NPCOp   = 2'd2;
                        if (is_jal) begin
                            RegWrite = 1'b1;
                            GPRSel   = 2'd2;
                            WDSel    = 2'd2;
                        end
                    end else if (is_jr) begin
                        PCWrite = 1'b1;
                        NPCOp   = 2'd3;
                    end
                end
                S_EXE: begin
                    ALUSrcA = 1'b1;
                    if (is_rtype) begin
                        ALUSrcB = 2'd0;
                        ALUOp   = r_aluop;
                    end else if (is_ialu) begin
                        ALUSrcB = 2'd2;
                        EXTOp   = i_ext;
                        ALUOp   = i_aluop;
                    end else if (is_lw || is_sw) begin
                        ALUSrcB = 2'd2;
                        EXTOp   = 1'b1;
                    end else if (is_beq || is_bne) begin
                        ALUSrcB     = 2'd0;
                        NPCOp       = 2'd1;
                        ALUOp       = is_beq ? ALUOp_EQL : ALUOp_BNE;
                        PCWriteCond = is_beq ? Zero : ~Zero;
                    end
                end
                S_MEM: begin
                    MemWrite = is_sw;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    GPRSel   = is_rtype ? 2'd1 : 2'd0;
                    WDSel    = is_lw ? 2'd1 : 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule
